// File: rtl/serial_frame_ctrl.sv
// Framed full-duplex serial link controller around a parallel-load / shift-right register.
// Optional even parity bit enabled by defining SERIAL_FRAME_PARITY_EN.
module serial_frame_ctrl #(
  parameter int NBITS = 4
) (
  input  logic             i_clk_2,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [NBITS-1:0] i_data_in,
  input  logic             i_ser_in,
  output logic             o_ser_out,
  output logic             o_busy,
  output logic             o_done,
  output logic [NBITS-1:0] o_rx_data,
  output logic             o_perr
);

  localparam int CW = $clog2(NBITS);

`ifdef SERIAL_FRAME_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_STOP} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [NBITS-1:0] r_shreg, w_shreg_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic             r_tx_par, w_tx_par_nxt;
  logic             r_ser_out, w_ser_out_nxt;
  logic [NBITS-1:0] r_rx_data, w_rx_data_nxt;
`ifdef SERIAL_FRAME_PARITY_EN
  logic             r_perr, w_perr_nxt;
`endif

  // ser_out is registered, so it is computed for the state being entered
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_count_nxt   = r_count;
    w_tx_par_nxt  = r_tx_par;
    w_ser_out_nxt = 1'b1;
    w_rx_data_nxt = r_rx_data;
`ifdef SERIAL_FRAME_PARITY_EN
    w_perr_nxt    = r_perr;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_shreg_nxt   = i_data_in;
          w_tx_par_nxt  = ^i_data_in;
          w_count_nxt   = '0;
          w_state_nxt   = S_START;
          w_ser_out_nxt = 1'b0;
        end
      end
      S_START: begin
        w_state_nxt   = S_SHIFT;
        w_ser_out_nxt = r_shreg[0];
      end
      S_SHIFT: begin
        w_shreg_nxt = {i_ser_in, r_shreg[NBITS-1:1]};
        w_count_nxt = r_count + 1'b1;
        if (r_count == CW'(NBITS - 1)) begin
`ifdef SERIAL_FRAME_PARITY_EN
          w_state_nxt   = S_PARITY;
          w_ser_out_nxt = r_tx_par;
`else
          w_state_nxt   = S_STOP;
          w_ser_out_nxt = 1'b1;
          w_rx_data_nxt = w_shreg_nxt;
`endif
        end else begin
          w_ser_out_nxt = w_shreg_nxt[0];
        end
      end
`ifdef SERIAL_FRAME_PARITY_EN
      S_PARITY: begin
        w_perr_nxt    = i_ser_in ^ (^r_shreg);
        w_rx_data_nxt = r_shreg;
        w_state_nxt   = S_STOP;
      end
`endif
      S_STOP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_2) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_count   <= '0;
      r_tx_par  <= 1'b0;
      r_ser_out <= 1'b1;
      r_rx_data <= '0;
`ifdef SERIAL_FRAME_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_count   <= w_count_nxt;
      r_tx_par  <= w_tx_par_nxt;
      r_ser_out <= w_ser_out_nxt;
      r_rx_data <= w_rx_data_nxt;
`ifdef SERIAL_FRAME_PARITY_EN
      r_perr    <= w_perr_nxt;
`endif
    end
  end

  assign o_ser_out = r_ser_out;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_STOP);
  assign o_rx_data = r_rx_data;
`ifdef SERIAL_FRAME_PARITY_EN
  assign o_perr    = r_perr;
`else
  assign o_perr    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Self-checking bench for serial_frame_ctrl: directed and random frames against a frame-level model.
// Follows SERIAL_FRAME_PARITY_EN the same way the design does.
module tb_serial_frame_ctrl;

  localparam int N = 4;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L = N + 2 + PAR;

  logic         clk_2 = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] data_in;
  logic         ser_in;
  logic         ser_out;
  logic         busy;
  logic         done;
  logic [N-1:0] rx_data;
  logic         perr;

  bit   loop_en;
  logic ser_drv;

  int checks = 0;
  int errors = 0;

  assign ser_in = loop_en ? ser_out : ser_drv;

  always #5 clk_2 = ~clk_2;

  serial_frame_ctrl #(.NBITS(N)) dut (
    .i_clk_2   (clk_2),
    .i_reset   (reset),
    .i_start   (start),
    .i_data_in (data_in),
    .i_ser_in  (ser_in),
    .o_ser_out (ser_out),
    .o_busy    (busy),
    .o_done    (done),
    .o_rx_data (rx_data),
    .o_perr    (perr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  // Entered one ns after a rising edge with the DUT in IDLE; returns the same way.
  task automatic run_frame(input logic [N-1:0] d, input bit loop, input logic [N-1:0] rxv,
                           input logic rxpar, input bit hold);
    logic         stream[$];
    logic [N-1:0] exp_rx;
    logic         rx_par_bit;
    logic         exp_perr;
    stream.push_back(1'b0);
    for (int j = 0; j < N; j++) stream.push_back(d[j]);
    if (PAR == 1) stream.push_back(^d);
    stream.push_back(1'b1);
    exp_rx     = loop ? d : rxv;
    rx_par_bit = loop ? ^d : rxpar;
    exp_perr   = (PAR == 1) ? (rx_par_bit ^ (^exp_rx)) : 1'b0;

    loop_en = loop;
    ser_drv = 1'b1;
    data_in = d;
    start   = 1'b1;
    @(negedge clk_2);
    chk("idle_ser_out", 32'(ser_out), 32'(1'b1));
    chk("idle_busy", 32'(busy), 32'(1'b0));
    step();
    if (hold) data_in = N'($urandom);
    else start = 1'b0;
    for (int k = 0; k < L; k++) begin
      if (k >= 1 && k <= N) ser_drv = rxv[k-1];
      else if (k == N + 1) ser_drv = rxpar;
      else ser_drv = 1'b1;
      @(negedge clk_2);
      chk($sformatf("ser_out_c%0d", k), 32'(ser_out), 32'(stream[k]));
      chk($sformatf("busy_c%0d", k), 32'(busy), 32'(1'b1));
      chk($sformatf("done_c%0d", k), 32'(done), 32'(k == L - 1));
      if (k == L - 1) begin
        chk("rx_data", 32'(rx_data), 32'(exp_rx));
        chk("perr", 32'(perr), 32'(exp_perr));
      end
      step();
      if (hold) data_in = N'($urandom);
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    loop_en = 1'b1;
    ser_drv = 1'b1;
    repeat (3) step();
    @(negedge clk_2);
    chk("rst_ser_out", 32'(ser_out), 32'(1'b1));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_done", 32'(done), 32'(1'b0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_perr", 32'(perr), 32'(1'b0));
    step();
    reset = 1'b0;

    run_frame(4'b1011, 1'b1, '0, 1'b0, 1'b0);
    run_frame(4'b0000, 1'b0, 4'b1001, 1'b0, 1'b0);
    run_frame(4'b0111, 1'b1, '0, 1'b0, 1'b0);
    run_frame(4'b0111, 1'b0, 4'b0111, 1'b0, 1'b0);

    // continuous start: each frame must restart after exactly one idle cycle
    for (int f = 0; f < 3; f++) run_frame(N'($urandom), 1'b1, '0, 1'b0, 1'b1);
    start = 1'b0;
    @(negedge clk_2);
    chk("hold_end_busy", 32'(busy), 32'(1'b0));
    step();

    for (int f = 0; f < 20; f++)
      run_frame(N'($urandom), 1'($urandom), N'($urandom), 1'($urandom), 1'b0);

    run_frame(4'b1011, 1'b1, '0, 1'b0, 1'b0);
    data_in = 4'b0110;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    @(negedge clk_2);
    chk("pre_rst_busy", 32'(busy), 32'(1'b1));
    reset = 1'b1;
    step();
    start = 1'b1;
    @(negedge clk_2);
    chk("midrst_ser_out", 32'(ser_out), 32'(1'b1));
    chk("midrst_busy", 32'(busy), 32'(1'b0));
    chk("midrst_done", 32'(done), 32'(1'b0));
    chk("midrst_rx_data", 32'(rx_data), 32'(0));
    chk("midrst_perr", 32'(perr), 32'(1'b0));
    step();
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk_2);
    chk("rst_start_busy", 32'(busy), 32'(1'b0));
    chk("rst_start_ser_out", 32'(ser_out), 32'(1'b1));
    step();

    run_frame(N'($urandom), 1'b1, '0, 1'b0, 1'b0);
    @(negedge clk_2);
    chk("final_idle_busy", 32'(busy), 32'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_ctrl.md
# serial_frame_ctrl

Controller that sequences a parallel-load / shift-right register as a framed, full-duplex serial link. It captures a parallel word on a start request, then emits a start bit, the data LSB-first, an optional parity bit and a stop bit. It shifts the incoming serial line into the register's MSB at the same time, so the received word is available when the frame completes. It sits between the board switches (word, start) and the LEDs or serial pins, and replaces manual toggling of the register's load/shift select.

## Interface
- NBITS, 4, data word width (≥2)
- clk_2  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; forces IDLE and the reset values below
- start  input  1  frame request; sampled only in IDLE
- data_in  input  NBITS  word to transmit, captured on the cycle start is accepted
- ser_in  input  1  incoming serial line, sampled during data and parity cycles
- ser_out  output  1  outgoing serial line, registered; idles high
- busy  output  1  high from START through STOP
- done  output  1  one-cycle pulse in the STOP cycle
- rx_data  output  NBITS  received word; valid when done=1, held until the next frame completes
- perr  output  1  receive parity error; valid when done=1

## Operation
- States: IDLE, START, SHIFT, PARITY (only with the macro), STOP.
- IDLE:
  - ser_out=1, busy=0.
  - If start=1, load shreg←data_in, tx parity←XOR of data_in, count←0, go to START.
- START:
  - ser_out=0, busy=1.
  - Next state is SHIFT.
- SHIFT, one cycle per bit, NBITS cycles:
  - ser_out=shreg[0].
  - At the cycle end, shreg←{ser_in, shreg[NBITS-1:1]} and count increments.
  - Leave when count reaches NBITS-1 at the edge, to PARITY if enabled, otherwise to STOP.
- PARITY:
  - ser_out=tx parity.
  - Sample ser_in; perr←ser_in XOR (XOR of shreg).
- STOP:
  - ser_out=1, done=1, rx_data←shreg (register updated at the STOP entry edge, so it is valid during STOP).
  - Next state is always IDLE.
- start outside IDLE is ignored, with no queuing. data_in is only read on the acceptance edge.
- Counter width is $clog2(NBITS); no wrap occurs because of the exit condition.
- Reset at any cycle, including mid-frame:
  - Next cycle is IDLE, ser_out=1, busy=0, done=0, rx_data=0, perr=0, shreg=0, count=0.
  - A partially received word is discarded.
- Reset and start together: reset wins.

## Timing
- Cycle 0: IDLE with start=1 sampled.
- Cycle 1: START.
- Cycles 2..NBITS+1: data bits 0..NBITS-1.
- Parity cycle NBITS+2 (if enabled).
- Then STOP.
- Frame length with busy high: NBITS+2 cycles, or NBITS+3 with parity.
- The earliest next start is accepted in the first IDLE cycle after STOP, which gives back-to-back frames with one idle-high cycle between them.
- ser_in is sampled at the rising edge ending each data or parity cycle. In loopback (ser_out→ser_in), rx_data equals the transmitted word.

## Configuration
- Macro SERIAL_FRAME_PARITY_EN.
- Defined:
  - The PARITY state exists; the frame carries an even parity bit after the data.
  - perr reports a mismatch of the received parity bit.
- Undefined:
  - No PARITY state; SHIFT goes directly to STOP.
  - perr is constant 0.

## Test plan
- Loopback, NBITS=4, no parity:
  - Stimulus: data_in=4'b1011, start pulse.
  - ser_out sequence is 0,1,1,0,1,1 (start, LSB-first data, stop).
  - busy is high for 6 cycles, done pulses in cycle 6, and rx_data=4'b1011.
- Independent ser_in:
  - Stimulus: data_in=4'b0000 while driving ser_in=1,0,0,1 across the data cycles.
  - rx_data=4'b1001 at done.
- Parity enabled, loopback:
  - Stimulus: data_in=4'b0111.
  - Parity bit is 1, frame length is 7 cycles, perr=0.
  - Forcing ser_in=0 in the parity cycle gives perr=1.
- start asserted continuously:
  - Frames repeat with exactly one IDLE cycle (ser_out=1) between STOP and the next START.
  - start pulses mid-frame are ignored.
- Reset asserted in the third data cycle:
  - Next cycle is IDLE with ser_out=1, busy=0, rx_data=0.
  - A start with reset=1 is not accepted.
